uart_rx_cmd_ctrl: RTL
=====================

Name: uart_rx_cmd_ctrl

Overview:
- Controller placed behind the UART byte receiver; consumes its `data`/`new_data` byte stream and frames packets.
- Packet format: SYNC, ADDR, LEN, LEN payload bytes, CKSUM.
- Validated packets are buffered, then replayed as a burst of register writes over a valid/ready interface.
- Invalid or stalled packets are discarded, and a one-cycle error strobe is raised.

Parameters:
- SYNC_BYTE, 8'hA5, start-of-packet marker.
- MAX_LEN, 16, maximum payload bytes per packet (buffer depth), range 1..255.
- TIMEOUT_CLKS, 8680, max clocks between bytes inside a packet (about 2 byte times at 115200 baud with CLK_PER_BIT=434).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  8  byte from the UART receiver.
- rx_new_data  in  1  one-cycle strobe; rx_data is valid in that cycle.
- wr_addr  out  8  write address.
- wr_data  out  8  write data.
- wr_valid  out  1  write request.
- wr_ready  in  1  sink accepts the write when wr_valid and wr_ready are both high.
- busy  out  1  high in every state except IDLE.
- pkt_done  out  1  one-cycle pulse after the last write of a packet is accepted.
- err_cksum  out  1  one-cycle pulse on checksum mismatch.
- err_len  out  1  one-cycle pulse when LEN==0 or LEN>MAX_LEN.
- err_timeout  out  1  one-cycle pulse on inter-byte timeout.
- err_overrun  out  1  one-cycle pulse when a byte arrives during EMIT (the byte is dropped).

Behaviour:
- Reset (async, any state):
  - state goes to IDLE.
  - All outputs 0; addr/len/idx/sum/timeout counters 0.
  - Payload buffer is not reset.
- All outputs are registered; error and done pulses appear the cycle after the causing event.
- Byte handling by state (only cycles with rx_new_data=1 act):
  - IDLE: byte==SYNC_BYTE goes to ADDR; any other byte is ignored with no error.
  - ADDR: addr<=byte, sum<=byte, go to LEN.
  - LEN: if byte==0 or byte>MAX_LEN, pulse err_len and go to IDLE. Otherwise len<=byte, sum<=sum+byte, idx<=0, go to PAYLOAD.
  - PAYLOAD: buf[idx]<=byte, sum<=sum+byte, idx<=idx+1. When idx==len-1, go to CKSUM.
  - CKSUM: if (sum+byte) mod 256 == 0, idx<=0 and go to EMIT. Otherwise pulse err_cksum and go to IDLE; no writes are issued.
  - A SYNC_BYTE value inside ADDR/LEN/PAYLOAD/CKSUM is treated as data; there is no resync.
- EMIT:
  - wr_valid=1, wr_addr=(addr+idx) mod 256 (wraps FF to 00), wr_data=buf[idx].
  - wr_addr and wr_data are held stable while wr_valid=1 and wr_ready=0.
  - On handshake: idx<=idx+1. After the handshake for idx==len-1, wr_valid=0 the next cycle, pkt_done pulses in that same cycle, and the state is IDLE.
  - Maximum rate is one write per clock.
  - rx_new_data in EMIT pulses err_overrun; the byte is not stored and not parsed, including SYNC_BYTE.
- Sum arithmetic: 8-bit, modulo 256. CKSUM is the two's complement of (ADDR+LEN+payload).
- Timeout:
  - Counter clears on every rx_new_data and on entry to ADDR.
  - It increments each clock in ADDR/LEN/PAYLOAD/CKSUM. When it reaches TIMEOUT_CLKS, pulse err_timeout and go to IDLE.
  - The counter is inactive in IDLE and EMIT.
  - If rx_new_data occurs in the same cycle the counter reaches the limit, the byte wins and the counter clears.
- busy=1 from the cycle after SYNC is accepted until the IDLE return cycle. It is also 0 in the cycle pkt_done pulses.
- Counter widths: $clog2(TIMEOUT_CLKS+1) for the timeout counter; $clog2(MAX_LEN+1) for idx.

Test Plan:
- Nominal packet: bytes A5 10 02 11 22 BB with wr_ready=1 → writes (10,11) then (11,22) on consecutive cycles, pkt_done single pulse, no error strobes.
- Address wrap with backpressure: packet A5 FF 02 01 02 FC, wr_ready low for 3 cycles at each write → writes (FF,01) and (00,02), with addr/data held stable while stalled.
- Bad checksum: A5 10 02 11 22 BC → err_cksum pulse, zero writes, busy=0; a following valid packet is accepted normally.
- Length errors: A5 10 00 → err_len; A5 10 11 (17 > MAX_LEN) → err_len; no writes in either case.
- Timeout: A5 10 02 11 then silence for TIMEOUT_CLKS clocks → err_timeout, IDLE. Also send a byte exactly at the limit cycle → no timeout.
- Overrun and reset: a byte arriving during EMIT (wr_ready=0) → err_overrun and the burst completes unchanged. Asserting rst mid-EMIT → wr_valid=0 immediately (async), state IDLE, and no pkt_done.

Source files
------------

// File: rtl/uart_rx_cmd_ctrl.sv
// rtl/uart_rx_cmd_ctrl.sv - frames SYNC/ADDR/LEN/payload/CKSUM packets from a UART byte stream
// and replays validated payloads as a burst of register writes.
module uart_rx_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 8680
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_new_data,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic       busy,
  output logic       pkt_done,
  output logic       err_cksum,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_CLKS);

  typedef enum logic [2:0] {IDLE, ADDR, LEN, PAYLOAD, CKSUM, EMIT} state_t;

  state_t            state;
  logic [7:0]        addr;
  logic [7:0]        sum;
  logic [IDX_W-1:0]  len;
  logic [IDX_W-1:0]  idx;
  logic [TO_W-1:0]   tcnt;

  // Depth rounded to a power of two so idx can address it without truncation.
  logic [7:0] payload_mem [2**IDX_W];

  always_ff @(posedge clk) begin
    if (state == PAYLOAD && rx_new_data) begin
      payload_mem[idx] <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= 8'h00;
      sum         <= 8'h00;
      len         <= '0;
      idx         <= '0;
      tcnt        <= '0;
      wr_addr     <= 8'h00;
      wr_data     <= 8'h00;
      wr_valid    <= 1'b0;
      busy        <= 1'b0;
      pkt_done    <= 1'b0;
      err_cksum   <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      pkt_done    <= 1'b0;
      err_cksum   <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_new_data && rx_data == SYNC_BYTE) begin
            state <= ADDR;
            busy  <= 1'b1;
            tcnt  <= '0;
          end
        end
        ADDR, LEN, PAYLOAD, CKSUM: begin
          // A byte arriving on the limit cycle takes priority over the timeout.
          if (rx_new_data) begin
            tcnt <= '0;
            case (state)
              ADDR: begin
                addr  <= rx_data;
                sum   <= rx_data;
                state <= LEN;
              end
              LEN: begin
                if (rx_data == 8'h00 || rx_data > MAX_LEN_B) begin
                  err_len <= 1'b1;
                  state   <= IDLE;
                  busy    <= 1'b0;
                end else begin
                  len   <= rx_data[IDX_W-1:0];
                  sum   <= sum + rx_data;
                  idx   <= '0;
                  state <= PAYLOAD;
                end
              end
              PAYLOAD: begin
                sum <= sum + rx_data;
                idx <= idx + IDX_W'(1);
                if (idx == len - IDX_W'(1)) begin
                  state <= CKSUM;
                end
              end
              default: begin
                if (sum + rx_data == 8'h00) begin
                  idx      <= '0;
                  state    <= EMIT;
                  wr_valid <= 1'b1;
                  wr_addr  <= addr;
                  wr_data  <= payload_mem[0];
                end else begin
                  err_cksum <= 1'b1;
                  state     <= IDLE;
                  busy      <= 1'b0;
                end
              end
            endcase
          end else if (tcnt == TO_LIMIT) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
            tcnt        <= '0;
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end
        EMIT: begin
          if (rx_new_data) begin
            err_overrun <= 1'b1;
          end
          if (wr_ready) begin
            if (idx == len - IDX_W'(1)) begin
              wr_valid <= 1'b0;
              pkt_done <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              idx     <= idx + IDX_W'(1);
              wr_addr <= wr_addr + 8'h01;
              wr_data <= payload_mem[idx + IDX_W'(1)];
            end
          end
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          wr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
